// File: rtl/qfilt_mask_pkg.sv
// Shared helpers for the qfilt union filter.
// Width helpers and the type-keep lookup.
package qfilt_pkg;

    localparam int MAX_TYPES = 256;

    function automatic int din_width(
        input int lvl,
        input int w_ctrl,
        input int w_din
    );
        return lvl + w_ctrl + w_din;
    endfunction

    function automatic int dout_width(
        input int lvl,
        input int w_dout
    );
        return lvl + w_dout;
    endfunction

    function automatic logic keep_sel(
        input logic [MAX_TYPES-1:0] mask,
        input logic [7:0]           ctrl
    );
        return mask[ctrl];
    endfunction

endpackage

// File: rtl/qfilt_mask_if.sv
// dti valid/ready link carrying one packed word.
// The producer drives valid/data, the consumer drives ready.
interface dti #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qfilt_mask_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qfilt_mask.sv
// Union-type queue filter: keeps items whose tag is enabled,
// folds end-of-transaction flags of dropped items into the last kept one.
module qfilt_mask
    import qfilt_pkg::*;
#(
    parameter int W_DIN     = 16,
    parameter int W_DOUT    = 16,
    parameter int W_CTRL    = 2,
    parameter int LVL       = 1,
    parameter logic [2**W_CTRL-1:0] SEL_MASK =
        {{(2**W_CTRL-1){1'b0}}, 1'b1},
    parameter int EMPTY_EOT = 0,
    parameter int W_CNT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    dti.consumer             din,
    dti.producer             dout,
    input  logic             cnt_clr,
    output logic [W_CNT-1:0] drop_cnt
);

    localparam int W_IN  = din_width(LVL, W_CTRL, W_DIN);
    localparam int W_OUT = dout_width(LVL, W_DOUT);

    logic [LVL-1:0]    in_eot;
    logic [W_CTRL-1:0] in_ctrl;
    logic [W_DIN-1:0]  in_data;

    logic              full;
    logic [LVL-1:0]    hold_eot;
    logic [W_DOUT-1:0] hold_data;

    logic keep, close, eot0, fire, hs, eff_empty;
    logic ld_kept, ld_ph, merge, drop;

    assign {in_eot, in_ctrl, in_data} = W_IN'(din.data);

    assign keep  = keep_sel(MAX_TYPES'(SEL_MASK), 8'(in_ctrl));
    assign close = &in_eot;
    assign eot0  = in_eot[0];

    // A kept item waits until its last eot is known: either the
    // next kept item shows up or the hold already closes.
    assign dout.valid = full &&
        ((din.valid && keep) || (&hold_eot));
    assign dout.data  = W_OUT'({hold_eot, hold_data});
    assign hs         = dout.valid && dout.ready;

    always_comb begin
        din.ready = 1'b1;
        unique case (1'b1)
            keep:          din.ready = !full || hs;
            !keep && !eot0: din.ready = 1'b1;
            !keep && eot0:
                din.ready = !full || !dout.valid || hs;
        endcase
    end

    // An outgoing hold is treated as free, so an eot arriving with
    // the handshake starts a new transaction instead of merging.
    assign fire      = din.valid && din.ready;
    assign eff_empty = !full || hs;
    assign ld_kept   = fire && keep;
    assign ld_ph     = fire && !keep && eot0 && eff_empty &&
                       close && (EMPTY_EOT != 0);
    assign merge     = fire && !keep && eot0 && !eff_empty;
    assign drop      = fire && !keep && !ld_ph;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= 1'b0;
            hold_eot  <= '0;
            hold_data <= '0;
        end else if (ld_kept) begin
            full      <= 1'b1;
            hold_eot  <= in_eot;
            hold_data <= W_DOUT'(in_data);
        end else if (ld_ph) begin
            full      <= 1'b1;
            hold_eot  <= in_eot;
            hold_data <= '0;
        end else if (merge) begin
            hold_eot  <= hold_eot | in_eot;
        end else if (hs) begin
            full      <= 1'b0;
            hold_eot  <= '0;
        end
    end

    sat_counter #(
        .W (W_CNT)
    ) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop),
        .clr (cnt_clr),
        .cnt (drop_cnt)
    );

endmodule

// File: tb/tb_qfilt_mask.sv
// Scoreboard bench for qfilt_mask: transaction-level model feeds
// an expected queue, a monitor pops it on every output handshake.
module tb_qfilt_mask;

    localparam int W_DIN  = 16;
    localparam int W_DOUT = 12;
    localparam int W_CTRL = 3;
    localparam int LVL    = 3;
    localparam int W_CNT  = 4;
    localparam logic [7:0] MASK = 8'hA6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clr = 1'b0;
    logic [W_CNT-1:0] drop_cnt;

    dti #(.W(LVL + W_CTRL + W_DIN)) din_if ();
    dti #(.W(LVL + W_DOUT))         dout_if ();

    qfilt_mask #(
        .W_DIN     (W_DIN),
        .W_DOUT    (W_DOUT),
        .W_CTRL    (W_CTRL),
        .LVL       (LVL),
        .SEL_MASK  (MASK),
        .EMPTY_EOT (1),
        .W_CNT     (W_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din_if),
        .dout     (dout_if),
        .cnt_clr  (cnt_clr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [14:0] exp_q[$];
    logic [7:0] mask_v = MASK;
    bit m_pend = 0;
    logic [2:0] m_eot = '0;
    logic [11:0] m_data = '0;
    int m_cnt = 0;
    int rdy_mode = 2;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_drop();
        if (m_cnt < 15) m_cnt++;
    endfunction

    // Stream semantics: an open kept item is released by the next kept
    // item or when its eot closes; dropped eots fold into it.
    function automatic void model_item(input logic [2:0] eot,
                                       input logic [2:0] ctrl,
                                       input logic [15:0] data);
        if (mask_v[ctrl]) begin
            if (m_pend) exp_q.push_back({m_eot, m_data});
            m_pend = 1;
            m_eot  = eot;
            m_data = data[11:0];
        end else if (!eot[0]) begin
            model_drop();
        end else if (m_pend) begin
            m_eot = m_eot | eot;
            model_drop();
        end else if (&eot) begin
            exp_q.push_back({eot, 12'h000});
        end else begin
            model_drop();
        end
        if (m_pend && (&m_eot)) begin
            exp_q.push_back({m_eot, m_data});
            m_pend = 0;
        end
    endfunction

    task automatic send(input logic [2:0] eot,
                        input logic [2:0] ctrl,
                        input logic [15:0] data);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        din_if.valid = 1'b1;
        din_if.data  = {eot, ctrl, data};
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            if (din_if.ready) begin
                hit = 1;
                model_item(eot, ctrl, data);
            end
            @(posedge clk);
            #1;
        end
        din_if.valid = 1'b0;
        if (!hit) chk("send_timeout", 32'(hit), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        m_cnt = 0;
        chk("clr", 32'(drop_cnt), 0);
    endtask

    function automatic logic [2:0] reot();
        logic [2:0] e;
        case ($urandom % 8)
            5: e = 3'b001;
            6: e = 3'b011;
            7: e = 3'b111;
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    task automatic rand_stream(input int n_items);
        for (int i = 0; i < n_items; i++) begin
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
            send(reot(), 3'($urandom % 8), 16'($urandom));
        end
        send(3'b111, 3'd0, 16'd0);
        drain();
        chk("rand_cnt", 32'(drop_cnt), 32'(m_cnt));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: dout_if.ready = ($urandom % 10) < 7;
                1: dout_if.ready = 1'b0;
                default: dout_if.ready = 1'b1;
            endcase
        end
    end

    bit stall = 0;
    logic [14:0] stall_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (stall) begin
                    chk("stable_valid", 32'(dout_if.valid), 1);
                    chk("stable_data", 32'(dout_if.data),
                        32'(stall_data));
                end
                if (dout_if.valid && dout_if.ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_out: got %0h expected none",
                                 dout_if.data);
                    end else begin
                        chk("dout", 32'(dout_if.data),
                            32'(exp_q.pop_front()));
                    end
                end
                stall = dout_if.valid && !dout_if.ready;
                stall_data = dout_if.data;
            end else begin
                stall = 0;
            end
        end
    end

    initial begin
        din_if.valid = 1'b0;
        din_if.data  = '0;
        dout_if.ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(dout_if.valid), 0);
        chk("rst_cnt", 32'(drop_cnt), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        send(3'b000, 3'd1, 16'd10);
        send(3'b000, 3'd0, 16'd11);
        send(3'b000, 3'd1, 16'd12);
        send(3'b111, 3'd0, 16'd13);
        drain();
        chk("dir1_cnt", 32'(drop_cnt), 2);
        clear_cnt();

        send(3'b000, 3'd1, 16'd5);
        send(3'b001, 3'd0, 16'd0);
        send(3'b000, 3'd1, 16'd6);
        send(3'b111, 3'd0, 16'd0);
        drain();
        chk("dir2_cnt", 32'(drop_cnt), 2);
        clear_cnt();

        send(3'b000, 3'd0, 16'd1);
        send(3'b111, 3'd0, 16'd2);
        drain();
        chk("dir3_cnt", 32'(drop_cnt), 1);

        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(3'b000, 3'd1, 16'd20);
        fork
            send(3'b000, 3'd2, 16'd21);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_ready", 32'(din_if.ready), 0);
                end
                rdy_mode = 2;
            end
        join
        send(3'b111, 3'd0, 16'd0);
        drain();
        chk("bp_cnt", 32'(drop_cnt), 32'(m_cnt));

        cnt_clr = 1'b1;
        send(3'b000, 3'd0, 16'd0);
        cnt_clr = 1'b0;
        m_cnt = 0;
        chk("clr_inc", 32'(drop_cnt), 0);

        rdy_mode = 0;
        rand_stream(400);
        chk("sat", 32'(drop_cnt), 15);

        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(3'b111, 3'd1, 16'd99);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", 32'(dout_if.valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(dout_if.valid), 0);
        chk("async_cnt", 32'(drop_cnt), 0);
        exp_q.delete();
        m_pend = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rand_stream(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
